regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 32: width of each register in bits.
REQ-002 Parameter NREGS, default 32: number of registers; power of two, at least 2.
REQ-003 Parameter ADDR_W, default log2(NREGS): width of each address field.
REQ-004 Parameter NREAD, default 2: number of independent read ports, 1..4.
REQ-005 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero, unwritable, and never pending.
REQ-006 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to matching read ports.
REQ-007 Clock  in  1  single clock; all state updates on its rising edge.
REQ-008 Reset  in  1  synchronous, active-high reset.
REQ-009 RegWrite  in  1  write enable.
REQ-010 WriteAddr  in  ADDR_W  write address.
REQ-011 WriteData  in  DATA_W  write data.
REQ-012 ReadAddr  in  NREAD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-013 ReadData  out  NREAD*DATA_W  packed read data, same packing as ReadAddr.
REQ-014 ReadPending  out  NREAD  pending (scoreboard) bit of the register addressed by each read port.
REQ-015 IssueValid  in  1  marks register IssueAddr as awaiting a future write.
REQ-016 IssueAddr  in  ADDR_W  register to mark pending.
REQ-017 ClearReq  in  1  starts a sequential clear of all registers.
REQ-018 Busy  out  1  high while a clear sequence runs.
REQ-019 ClearDone  out  1  one-cycle pulse when a clear sequence completes.

Function
REQ-020 A write is effective when RegWrite=1, Busy=0, and not (ZERO_REG=1 and WriteAddr=0); the register updates at the next rising edge.
REQ-021 Reads are combinational; ReadData[k] equals register[ReadAddr[k]] with no clock latency.
REQ-022 With ZERO_REG=1, a read of address 0 returns 0 regardless of bypass or any write.
REQ-023 With BYPASS=1, an effective write whose WriteAddr matches ReadAddr[k] drives WriteData on ReadData[k] in that same cycle; with BYPASS=0, the old value is returned until the next edge.
REQ-024 Scoreboard: when Busy=0, IssueValid=1 sets pending[IssueAddr] at the next edge; an effective write clears pending[WriteAddr].
REQ-025 If issue and an effective write target the same address in the same cycle, pending ends set (the new producer wins).
REQ-026 IssueValid to address 0 with ZERO_REG=1 is ignored.
REQ-027 ReadPending[k] is combinational from pending[ReadAddr[k]] and is not bypassed.
REQ-028 FSM states: IDLE and CLEAR.
REQ-029 In IDLE, ClearReq=1 moves the FSM to CLEAR and loads the clear counter with 0.
REQ-030 In CLEAR, each cycle writes 0 to register[counter], clears pending[counter], and increments the counter.
REQ-031 While the counter is NREGS-1, the FSM returns to IDLE and asserts ClearDone for exactly that next cycle, so the sequence spans NREGS cycles.
REQ-032 Busy=1 exactly while in CLEAR; during CLEAR, RegWrite, IssueValid, and ClearReq are ignored.
REQ-033 Reads during CLEAR return the current contents, partially cleared; bypass is inactive.

Reset
REQ-034 Reset=1 at a rising edge zeroes all registers and pending bits, sets the FSM to IDLE, the counter to 0, and ClearDone to 0, and overrides all other inputs that cycle.
REQ-035 Reset asserted in the middle of a clear aborts the sequence with no ClearDone pulse.
REQ-036 After reset, all ReadData and ReadPending read 0 and Busy=0.

Structure
REQ-037 Shared package regfile_pkg holds the parameter defaults and the FSM state enumeration (ST_IDLE, ST_CLEAR).
REQ-038 Sub-module regfile_scoreboard holds the NREGS pending bits, issue/clear/reset logic, and the per-port ReadPending lookup.

Verification
REQ-039 Write 0xDEADBEEF to r5, then read r5 on all ports the next cycle -> 0xDEADBEEF on every port.
REQ-040 BYPASS=1: write 0x12345678 to r7 while reading r7 -> 0x12345678 in the same cycle; BYPASS=0 -> old value, then 0x12345678 after the edge.
REQ-041 ZERO_REG=1: write 0xFFFFFFFF to r0, issue r0 -> reads 0, ReadPending 0.
REQ-042 Issue r3, then write r3 while issuing r3 in the same cycle -> ReadPending stays 1; a following write to r3 alone -> 0.
REQ-043 Fill all registers, pulse ClearReq -> Busy high for 32 cycles, a write to r9 mid-clear is ignored, ClearDone pulses once, all registers read 0.
REQ-044 Reset asserted at clear cycle 10 -> all registers 0, Busy=0 the next cycle, no ClearDone pulse.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared parameter defaults and clear-sequencer state encoding
package regfile_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NREGS    = 32;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with issue/clear and per-port lookup
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int NREAD  = DEF_NREAD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_en,
  input  logic [ADDR_W-1:0]       set_addr,
  input  logic                    clr_en,
  input  logic [ADDR_W-1:0]       clr_addr,
  input  logic [NREAD*ADDR_W-1:0] read_addr,
  output logic [NREAD-1:0]        read_pending
);
  logic [NREGS-1:0] pend_q, pend_d;
  // clear first so a same-cycle issue (new producer) wins over the retiring write
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_addr] = 1'b0;
    if (set_en) pend_d[set_addr] = 1'b1;
  end
  // pending bit storage
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else pend_q <= pend_d;
  end
  for (genvar k = 0; k < NREAD; k++) begin : g_rp
    assign read_pending[k] = pend_q[read_addr[k*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/regfile_param.sv
// regfile_param: multi-port register file with bypass, scoreboard and sequential clear
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREGS    = DEF_NREGS,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    RegWrite,
  input  logic [ADDR_W-1:0]       WriteAddr,
  input  logic [DATA_W-1:0]       WriteData,
  input  logic [NREAD*ADDR_W-1:0] ReadAddr,
  output logic [NREAD*DATA_W-1:0] ReadData,
  output logic [NREAD-1:0]        ReadPending,
  input  logic                    IssueValid,
  input  logic [ADDR_W-1:0]       IssueAddr,
  input  logic                    ClearReq,
  output logic                    Busy,
  output logic                    ClearDone
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              busy, wr_eff, iss_eff;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  assign busy    = state_q == ST_CLEAR;
  assign wr_eff  = RegWrite && !busy && !(ZERO_REG != 0 && WriteAddr == '0);
  assign iss_eff = IssueValid && !busy && !(ZERO_REG != 0 && IssueAddr == '0);
  assign Busy      = busy;
  assign ClearDone = done_q;
  // clear sequencer: walks the counter over every register, pulses done after the last
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      state_d = ClearReq ? ST_CLEAR : ST_IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(NREGS - 1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end
  // sequencer state, counter and registered done pulse
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  // register next-state: the clear sequence owns the write path while busy
  always_comb begin
    regs_d = regs_q;
    if (busy) regs_d[cnt_q] = '0;
    else if (wr_eff) regs_d[WriteAddr] = WriteData;
  end
  // register storage
  always_ff @(posedge Clock) begin
    if (Reset) for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    else regs_q <= regs_d;
  end
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = ReadAddr[k*ADDR_W +: ADDR_W];
    assign ReadData[k*DATA_W +: DATA_W] =
      (ZERO_REG != 0 && ra == '0)              ? '0 :
      (BYPASS != 0 && wr_eff && WriteAddr == ra) ? WriteData : regs_q[ra];
  end
  regfile_scoreboard #(.NREGS(NREGS), .ADDR_W(ADDR_W), .NREAD(NREAD)) u_sb (
    .clk         (Clock),
    .rst         (Reset),
    .set_en      (iss_eff),
    .set_addr    (IssueAddr),
    .clr_en      (wr_eff || busy),
    .clr_addr    (busy ? cnt_q : WriteAddr),
    .read_addr   (ReadAddr),
    .read_pending(ReadPending)
  );
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: random and directed checks against an array-based reference model
module tb_regfile_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [9:0]  ra = '0;
  logic        iv = 1'b0;
  logic [4:0]  ia = '0;
  logic        clr = 1'b0;
  logic [63:0] rd, rd_nb;
  logic [1:0]  rp, rp_nb;
  logic        busy_o, done_o, busy_nb, done_nb;
  int          nchk = 0, nerr = 0, ndone = 0;
  logic [31:0] mem [32];
  bit          pend [32];
  bit          mbusy, mdone;
  int          midx;

  always #5 clk = ~clk;

  regfile_param dut (
    .Clock(clk), .Reset(rst), .RegWrite(we), .WriteAddr(wa), .WriteData(wd),
    .ReadAddr(ra), .ReadData(rd), .ReadPending(rp), .IssueValid(iv), .IssueAddr(ia),
    .ClearReq(clr), .Busy(busy_o), .ClearDone(done_o)
  );
  regfile_param #(.BYPASS(0)) dut_nb (
    .Clock(clk), .Reset(rst), .RegWrite(we), .WriteAddr(wa), .WriteData(wd),
    .ReadAddr(ra), .ReadData(rd_nb), .ReadPending(rp_nb), .IssueValid(iv), .IssueAddr(ia),
    .ClearReq(clr), .Busy(busy_nb), .ClearDone(done_nb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && !mbusy && we && int'(wa) == a) return wd;
    return mem[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mem[i] = '0; pend[i] = 0; end
      mbusy = 0; midx = 0; mdone = 0;
    end else if (mbusy) begin
      mem[midx] = '0;
      pend[midx] = 0;
      mdone = (midx == 31);
      mbusy = (midx != 31);
      midx++;
    end else begin
      mdone = 0;
      if (we && wa != 0) begin mem[wa] = wd; pend[wa] = 0; end
      if (iv && ia != 0) pend[ia] = 1;
      if (clr) begin mbusy = 1; midx = 0; end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int a;
      a = int'(ra[k*5 +: 5]);
      chk("rd", rd[k*32 +: 32], exp_rd(a, 1));
      chk("rd_nobypass", rd_nb[k*32 +: 32], exp_rd(a, 0));
      chk("pending", 32'(rp[k]), 32'(pend[a]));
    end
    chk("busy", 32'(busy_o), 32'(mbusy));
    chk("clear_done", 32'(done_o), 32'(mdone));
    chk("busy_nobypass", 32'(busy_nb), 32'(mbusy));
    if (done_o) ndone++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we = 0; iv = 0; clr = 0; rst = 0;
  endtask

  initial begin
    int n, d0;
    for (int i = 0; i < 32; i++) begin mem[i] = '0; pend[i] = 0; end
    mbusy = 0; mdone = 0; midx = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    ra = {5'd31, 5'd5};
    #1;
    chk("reset_rd0", rd[31:0], 32'h0);
    chk("reset_rd1", rd[63:32], 32'h0);
    chk("reset_pend", 32'(rp), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    chk("reset_done", 32'(done_o), 32'h0);

    we = 1; wa = 5; wd = 32'hDEADBEEF; cyc();
    idle(); ra = {5'd5, 5'd5}; #1;
    chk("r5_p0", rd[31:0], 32'hDEADBEEF);
    chk("r5_p1", rd[63:32], 32'hDEADBEEF);
    cyc();

    we = 1; wa = 7; wd = 32'h11111111; cyc();
    wd = 32'h12345678; ra = {5'd7, 5'd7}; #1;
    chk("bypass_new", rd[31:0], 32'h12345678);
    chk("nobypass_old", rd_nb[31:0], 32'h11111111);
    cyc();
    idle(); #1;
    chk("nobypass_after", rd_nb[31:0], 32'h12345678);
    cyc();

    we = 1; wa = 0; wd = 32'hFFFFFFFF; iv = 1; ia = 0; ra = '0; #1;
    chk("r0_bypass", rd[31:0], 32'h0);
    cyc();
    idle(); #1;
    chk("r0_read", rd[31:0], 32'h0);
    chk("r0_pend", 32'(rp[0]), 32'h0);
    cyc();

    iv = 1; ia = 3; cyc();
    we = 1; wa = 3; wd = 32'h33; cyc();
    idle(); ra = {5'd3, 5'd3}; #1;
    chk("pend_new_producer", 32'(rp[0]), 32'h1);
    we = 1; wa = 3; wd = 32'h34; cyc();
    idle(); #1;
    chk("pend_retired", 32'(rp[0]), 32'h0);
    cyc();

    for (int i = 0; i < 32; i++) begin
      we = 1; wa = 5'(i); wd = $urandom; iv = 1; ia = 5'(31 - i); cyc();
    end
    idle();
    d0 = ndone;
    clr = 1; cyc(); clr = 0;
    n = 0;
    while (busy_o && n < 100) begin
      we = (n == 12); wa = 9; wd = 32'hABCD0009; iv = (n == 12); ia = 9; clr = (n == 20);
      cyc(); n++;
    end
    idle();
    chk("busy_len", 32'(n), 32'd32);
    cyc();
    chk("done_pulses", 32'(ndone - d0), 32'd1);
    for (int i = 0; i < 32; i += 2) begin
      ra = {5'(i + 1), 5'(i)}; #1;
      chk("cleared_p0", rd[31:0], 32'h0);
      chk("cleared_p1", rd[63:32], 32'h0);
      chk("cleared_pend", 32'(rp), 32'h0);
      cyc();
    end

    for (int i = 1; i < 32; i++) begin
      we = 1; wa = 5'(i); wd = $urandom | 32'h1; cyc();
    end
    idle();
    d0 = ndone;
    clr = 1; cyc(); clr = 0;
    repeat (10) cyc();
    rst = 1; cyc(); rst = 0;
    chk("abort_busy", 32'(busy_o), 32'h0);
    repeat (3) cyc();
    chk("abort_no_done", 32'(ndone - d0), 32'h0);
    for (int i = 0; i < 32; i += 2) begin
      ra = {5'(i + 1), 5'(i)}; #1;
      chk("abort_zero", rd[31:0] | rd[63:32], 32'h0);
      cyc();
    end

    for (int c = 0; c < 1500; c++) begin
      we = ($urandom_range(0, 2) != 0);
      wa = 5'($urandom);
      wd = $urandom;
      iv = ($urandom_range(0, 2) == 0);
      ia = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? {wa, wa} : 10'($urandom);
      clr = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 399) == 0);
      cyc();
    end
    idle();
    cyc();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
